// File: rtl/seq_cla_pkg.sv
// Shared types for the sequential carry-lookahead adder/subtractor:
// FSM state encoding and the slice-counter width helper.
package seq_cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A one-slice datapath still needs a 1-bit counter so the port widths stay legal.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder: generate/propagate, flattened
// lookahead carries, sum, carry out and the carry into the slice MSB.
module cla_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, each term built directly
  // from g/p so no carry depends on a previous carry.
  always_comb begin
    logic term;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      term = cin;
      for (int k = 0; k <= i; k++) begin
        term = term & p[k];
      end
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        c[i+1] = c[i+1] | term;
      end
    end
  end

  assign sum   = p ^ c[SLICE-1:0];
  assign cout  = c[SLICE];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/seq_cla_addsub.sv
// Multi-cycle adder/subtractor: one SLICE-bit lookahead slice reused over
// WIDTH/SLICE cycles, carry rippled through a register between cycles.
//
// state | meaning
// IDLE  | ready for a new operation (in_ready=1)
// RUN   | one slice per cycle, LSB slice first
// DONE  | result and flags held with out_valid=1 until out_ready
module seq_cla_addsub
  import seq_cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (SLICE <= 0 || WIDTH <= 0 || (WIDTH % SLICE) != 0) begin : g_bad_params
    $error("seq_cla_addsub: WIDTH must be a positive multiple of SLICE");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] s_sl;
  logic             cout_sl;
  logic             c_msb_sl;
  logic [WIDTH-1:0] sum_nxt;

  always_comb begin
    int idx;
    idx     = int'(cnt);
    a_sl    = a_q[idx*SLICE +: SLICE];
    b_sl    = b_q[idx*SLICE +: SLICE];
    sum_nxt = sum_q;
    sum_nxt[idx*SLICE +: SLICE] = s_sl;
  end

  cla_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .a     (a_sl),
    .b     (b_sl),
    .cin   (carry_q),
    .sum   (s_sl),
    .cout  (cout_sl),
    .c_msb (c_msb_sl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      sum_q     <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction as A + ~B + 1: the +1 enters through the carry register.
            a_q      <= a;
            b_q      <= b ^ {WIDTH{sub}};
            carry_q  <= sub;
            cnt      <= '0;
            sum_q    <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_nxt;
          carry_q <= cout_sl;
          if (cnt == LAST) begin
            c_out     <= cout_sl;
            ovf       <= c_msb_sl ^ cout_sl;
            zero      <= (sum_nxt == '0);
            cnt       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_seq_cla_addsub.sv
// Directed and randomized checks of seq_cla_addsub at 16/4, 4/4 and 32/8.
module tb_seq_cla_addsub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // default 16/4 instance
  logic        in_valid, in_ready, sub, out_valid, out_ready, c_out, ovf, zero;
  logic [15:0] a, b, sum;

  seq_cla_addsub #(.WIDTH(16), .SLICE(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero)
  );

  // 4/4 instance (single slice)
  logic       v4_in_valid, v4_in_ready, v4_sub, v4_out_valid, v4_out_ready;
  logic       v4_c_out, v4_ovf, v4_zero;
  logic [3:0] v4_a, v4_b, v4_sum;

  seq_cla_addsub #(.WIDTH(4), .SLICE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4_in_valid), .in_ready(v4_in_ready),
    .a(v4_a), .b(v4_b), .sub(v4_sub), .out_valid(v4_out_valid),
    .out_ready(v4_out_ready), .sum(v4_sum), .c_out(v4_c_out), .ovf(v4_ovf),
    .zero(v4_zero)
  );

  // 32/8 instance
  logic        w_in_valid, w_in_ready, w_sub, w_out_valid, w_out_ready;
  logic        w_c_out, w_ovf, w_zero;
  logic [31:0] w_a, w_b, w_sum;

  seq_cla_addsub #(.WIDTH(32), .SLICE(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .sub(w_sub), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .sum(w_sum), .c_out(w_c_out), .ovf(w_ovf),
    .zero(w_zero)
  );

  // Accept one op on the 16-bit DUT, scramble inputs, count edges to out_valid.
  task automatic do_op16(input logic [15:0] ta, input logic [15:0] tb_,
                         input logic ts, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    a = ta; b = tb_; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; sub = ~ts;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release16();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 ||
        c_out !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b sum=%h c=%b v=%b z=%b, want 1 0 0000 0 0 0",
               in_ready, out_valid, sum, c_out, ovf, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat;
    do_op16(16'hFFFF, 16'h0001, 1'b0, lat);
    n_tests++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL add_wrap_latency: got %0d want 4", lat);
    end
    n_tests++;
    if (sum !== 16'h0000 || c_out !== 1'b1 || ovf !== 1'b0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL add_wrap: sum=%h c=%b v=%b z=%b want 0000 1 0 1", sum, c_out, ovf, zero);
    end
    release16();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL add_wrap_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end

    do_op16(16'h7FFF, 16'h0001, 1'b0, lat);
    n_tests++;
    if (lat !== 4 || sum !== 16'h8000 || c_out !== 1'b0 || ovf !== 1'b1 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL add_ovf: lat=%0d sum=%h c=%b v=%b z=%b want 4 8000 0 1 0",
               lat, sum, c_out, ovf, zero);
    end
    release16();
  endtask

  task automatic test_sub();
    int lat;
    do_op16(16'h0003, 16'h0005, 1'b1, lat);
    n_tests++;
    if (lat !== 4 || sum !== 16'hFFFE || c_out !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow: lat=%0d sum=%h c=%b v=%b z=%b want 4 fffe 0 0 0",
               lat, sum, c_out, ovf, zero);
    end
    release16();

    do_op16(16'h8000, 16'h0001, 1'b1, lat);
    n_tests++;
    if (sum !== 16'h7FFF || c_out !== 1'b1 || ovf !== 1'b1 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_ovf: sum=%h c=%b v=%b z=%b want 7fff 1 1 0", sum, c_out, ovf, zero);
    end
    release16();

    do_op16(16'h1234, 16'h1234, 1'b1, lat);
    n_tests++;
    if (sum !== 16'h0000 || c_out !== 1'b1 || ovf !== 1'b0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_self: sum=%h c=%b v=%b z=%b want 0000 1 0 1", sum, c_out, ovf, zero);
    end
    release16();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    do_op16(16'h00F0, 16'h0F0F, 1'b0, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 16'($urandom);
      b = 16'($urandom);
      sub = i[1];
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h0FFF ||
          c_out !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
        bad++;
        $display("FAIL backpressure_hold[%0d]: ov=%b ir=%b sum=%h c=%b v=%b z=%b want 1 0 0fff 0 0 0",
                 i, out_valid, in_ready, sum, c_out, ovf, zero);
      end
    end
    n_tests++;
    if (bad != 0) n_fail++;
    in_valid = 1'b0;
    release16();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    a = 16'hAAAA; b = 16'h5555; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 ||
        c_out !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: ir=%b ov=%b sum=%h c=%b v=%b z=%b want 1 0 0000 0 0 0",
               in_ready, out_valid, sum, c_out, ovf, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op16(16'h1234, 16'h1111, 1'b0, lat);
    n_tests++;
    if (lat !== 4 || sum !== 16'h2345 || c_out !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_op: lat=%0d sum=%h c=%b v=%b z=%b want 4 2345 0 0 0",
               lat, sum, c_out, ovf, zero);
    end
    release16();
  endtask

  task automatic test_sweep_w4();
    logic [3:0] ta, tb_, bb;
    logic       ts, e_ovf;
    logic [4:0] r;
    int         lat, n;
    for (int i = 0; i < 1000; i++) begin
      ta = 4'($urandom); tb_ = 4'($urandom); ts = 1'($urandom);
      bb = ts ? ~tb_ : tb_;
      r  = {1'b0, ta} + {1'b0, bb} + {4'b0, ts};
      e_ovf = ts ? (ta[3] != tb_[3] && r[3] != ta[3]) : (ta[3] == tb_[3] && r[3] != ta[3]);
      n = 0;
      while (!v4_in_ready && n < 20) begin
        @(posedge clk); #1; n++;
      end
      v4_a = ta; v4_b = tb_; v4_sub = ts; v4_in_valid = 1'b1;
      @(posedge clk); #1;
      v4_in_valid = 1'b0; v4_a = ~ta; v4_b = ~tb_;
      lat = 0;
      while (!v4_out_valid && lat < 20) begin
        @(posedge clk); #1; lat++;
      end
      n_tests++;
      if (lat !== 1 || v4_sum !== r[3:0] || v4_c_out !== r[4] || v4_ovf !== e_ovf ||
          v4_zero !== (r[3:0] == 4'h0)) begin
        n_fail++;
        $display("FAIL sweep_w4 %h %s %h: lat=%0d sum=%h c=%b v=%b z=%b want 1 %h %b %b %b",
                 ta, ts ? "-" : "+", tb_, lat, v4_sum, v4_c_out, v4_ovf, v4_zero,
                 r[3:0], r[4], e_ovf, r[3:0] == 4'h0);
      end
      v4_out_ready = 1'b1;
      @(posedge clk); #1;
      v4_out_ready = 1'b0;
    end
  endtask

  task automatic test_sweep_w32();
    logic [31:0] ta, tb_, bb;
    logic        ts, e_ovf;
    logic [32:0] r;
    int          lat, n;
    for (int i = 0; i < 1000; i++) begin
      ta = $urandom; tb_ = $urandom; ts = 1'($urandom);
      if (i == 0) begin ta = 32'hFFFF_FFFF; tb_ = 32'h1; ts = 1'b0; end
      if (i == 1) begin ta = 32'h8000_0000; tb_ = 32'h1; ts = 1'b1; end
      bb = ts ? ~tb_ : tb_;
      r  = {1'b0, ta} + {1'b0, bb} + {32'b0, ts};
      e_ovf = ts ? (ta[31] != tb_[31] && r[31] != ta[31]) : (ta[31] == tb_[31] && r[31] != ta[31]);
      n = 0;
      while (!w_in_ready && n < 20) begin
        @(posedge clk); #1; n++;
      end
      w_a = ta; w_b = tb_; w_sub = ts; w_in_valid = 1'b1;
      @(posedge clk); #1;
      w_in_valid = 1'b0; w_a = ~ta; w_b = ~tb_; w_sub = ~ts;
      lat = 0;
      while (!w_out_valid && lat < 20) begin
        @(posedge clk); #1; lat++;
      end
      n_tests++;
      if (lat !== 4 || w_sum !== r[31:0] || w_c_out !== r[32] || w_ovf !== e_ovf ||
          w_zero !== (r[31:0] == 32'h0)) begin
        n_fail++;
        $display("FAIL sweep_w32 %h %s %h: lat=%0d sum=%h c=%b v=%b z=%b want 4 %h %b %b %b",
                 ta, ts ? "-" : "+", tb_, lat, w_sum, w_c_out, w_ovf, w_zero,
                 r[31:0], r[32], e_ovf, r[31:0] == 32'h0);
      end
      w_out_ready = 1'b1;
      @(posedge clk); #1;
      w_out_ready = 1'b0;
    end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    v4_in_valid = 1'b0; v4_out_ready = 1'b0; v4_a = '0; v4_b = '0; v4_sub = 1'b0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_a = '0; w_b = '0; w_sub = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_sweep_w4();
    test_sweep_w32();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_cla_addsub.md
# seq_cla_addsub

Multi-cycle, parametrised adder/subtractor for the calculator datapath. Reuses a single SLICE-bit carry-lookahead slice over WIDTH/SLICE cycles, rippling the carry through a register, so wide operands are handled with one slice's area. It sits between the operand registers and the result/flag register, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 16, operand and result width; must be a positive multiple of SLICE.
- SLICE, 4, bits processed per cycle by the lookahead slice.
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A, two's complement or unsigned.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.

## Operation
- N = WIDTH/SLICE slices; slice k covers bits [k*SLICE +: SLICE], LSB slice first.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch a, b^{WIDTH{sub}}, set carry register = sub, clear slice counter, clear sum register, go RUN.
- RUN: in_ready=0. Each cycle, slice k adds latched A/B bits with carry register, writes SLICE sum bits into sum register, updates carry register with slice carry out; counter increments. After slice N−1: capture c_out = slice carry out, ovf = carry into MSB XOR carry out of MSB, zero = (full sum == 0); go DONE.
- DONE: out_valid=1, in_ready=0, outputs stable. On out_ready: go IDLE, out_valid deasserts next cycle.
- in_valid outside IDLE is ignored; a/b/sub changes after acceptance do not affect the result.
- Arithmetic modulo 2^WIDTH; no saturation. ovf is meaningful for signed interpretation, c_out for unsigned.
- Reset (any state, asynchronous): state=IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0, zero=0, counter=0, carry=0. An in-flight operation is discarded with no output.

## Timing
- Accept at edge E0; slices computed at edges E1..EN; out_valid high from EN through the edge where out_ready is sampled high.
- Latency accept → out_valid: N cycles (4 for defaults). N=1 gives 1 cycle.
- Throughput: one op per N+2 cycles minimum (accept, N RUN, handshake-out then return to IDLE); no overlap of accept with DONE.
- out_ready held low: DONE holds indefinitely, outputs unchanged.
- All outputs registered; no combinational path from inputs to outputs except none (in_ready from state only).
- Counter width: max(1, $clog2(N)).

## Structure
- Package seq_cla_pkg: state enum (IDLE, RUN, DONE), helper function for counter width.
- Sub-module cla_slice (parameter SLICE): combinational generate/propagate, lookahead carries, sum and cout; instantiated once.
- Top holds FSM, operand, carry, counter and result registers; elaboration check that WIDTH % SLICE == 0.

## Test plan
- Add 0xFFFF + 0x0001 → sum 0x0000, c_out=1, ovf=0, zero=1, out_valid exactly 4 cycles after accept.
- Add 0x7FFF + 0x0001 → sum 0x8000, c_out=0, ovf=1, zero=0.
- Sub 0x0003 − 0x0005 → sum 0xFFFE, c_out=0, ovf=0; sub 0x8000 − 0x0001 → 0x7FFF, c_out=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, toggle in_valid and a/b → outputs stable, in_ready=0, no new op accepted; out_ready=1 → IDLE next cycle.
- Reset asserted mid-RUN (after slice 2) → all outputs at reset values immediately, in_ready=1; next op 0x1234+0x1111 → 0x2345.
- Parameter sweep WIDTH=SLICE=4 and WIDTH=32,SLICE=8 against a reference model on 1000 random ops each → bit-exact sum and flags, latency N.
